// File: rtl/sram_strobe_ctrl.sv
// rtl/sram_strobe_ctrl.sv - req/ack to registered async-SRAM strobe sequencer
// Optional post-reset zero-fill engine is built when SRAM_CLEAR_EN is defined.
module sram_strobe_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 11,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 ack,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 clr_done,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_din,
  output logic                 sram_nwe,
  output logic                 sram_nen,
  input  logic [DATA_BITS-1:0] sram_dout
);

  typedef enum logic [2:0] {CLEAR, IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef SRAM_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  localparam logic   RST_WE    = 1'b1;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_WE    = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_BITS-1:0] sram_din_q, sram_din_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 sram_nwe_q, sram_nwe_d;
  logic                 sram_nen_q, sram_nen_d;
  logic                 ack_q, ack_d;
`ifdef SRAM_CLEAR_EN
  logic                 clr_active_q, clr_active_d;
  logic                 clr_done_q, clr_done_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    rdata_d     = rdata_q;
`ifdef SRAM_CLEAR_EN
    clr_active_d = clr_active_q;
    clr_done_d   = clr_done_q;
`endif
    case (state_q)
`ifdef SRAM_CLEAR_EN
      // Address 0 and zero data are already on the bus from reset, so this
      // cycle doubles as the first SETUP.
      CLEAR: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
`endif
      IDLE: begin
        if (req) begin
          state_d     = SETUP;
          we_d        = we;
          sram_addr_d = addr;
          sram_din_d  = wdata;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) rdata_d = sram_dout;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = DONE;
`ifdef SRAM_CLEAR_EN
        if (clr_active_q) begin
          if (&sram_addr_q) begin
            state_d      = IDLE;
            clr_active_d = 1'b0;
            clr_done_d   = 1'b1;
          end else begin
            state_d     = SETUP;
            sram_addr_d = sram_addr_q + ADDR_BITS'(1);
          end
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so every SRAM pin is a flop.
    sram_nen_d = !((state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD));
    sram_nwe_d = !((state_d == STROBE) && we_d);
    ack_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= 4'd0;
      we_q        <= RST_WE;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      rdata_q     <= '0;
      sram_nwe_q  <= 1'b1;
      sram_nen_q  <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      rdata_q     <= rdata_d;
      sram_nwe_q  <= sram_nwe_d;
      sram_nen_q  <= sram_nen_d;
      ack_q       <= ack_d;
    end
  end

`ifdef SRAM_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_active_q <= 1'b1;
      clr_done_q   <= 1'b0;
    end else begin
      clr_active_q <= clr_active_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign clr_done = clr_done_q;
`else
  assign clr_done = 1'b1;
`endif

  assign busy      = (state_q != IDLE);
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;
  assign sram_nwe  = sram_nwe_q;
  assign sram_nen  = sram_nen_q;

endmodule

// File: tb/tb_sram_strobe_ctrl.sv
// tb/tb_sram_strobe_ctrl.sv - self-checking bench for sram_strobe_ctrl
// Covers SRAM_CLEAR_EN when the macro is defined for the build.
module tb_sram_strobe_ctrl;
  localparam int DB = 8;
  localparam int AB = 11;
  localparam int W  = 2;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic req1 = 1'b0;
  logic we = 1'b0;
  logic [AB-1:0] addr = '0;
  logic [DB-1:0] wdata = '0;

  logic busy, ack, clr_done, sram_nwe, sram_nen;
  logic [DB-1:0] rdata, sram_din, sram_dout;
  logic [AB-1:0] sram_addr;
  logic busy1, ack1, clr_done1, sram_nwe1, sram_nen1;
  logic [DB-1:0] rdata1, sram_din1, sram_dout1;
  logic [AB-1:0] sram_addr1;

  logic [DB-1:0] mem [0:DEPTH-1];
  logic [DB-1:0] mem1 [0:DEPTH-1];
  logic [DB-1:0] ref_mem [0:DEPTH-1];
  logic [DB-1:0] last_rd = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_strobe_ctrl #(.DATA_BITS(DB), .ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .clr_done(clr_done),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_nwe(sram_nwe),
    .sram_nen(sram_nen), .sram_dout(sram_dout)
  );

  sram_strobe_ctrl #(.DATA_BITS(DB), .ADDR_BITS(AB), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy1), .ack(ack1), .rdata(rdata1), .clr_done(clr_done1),
    .sram_addr(sram_addr1), .sram_din(sram_din1), .sram_nwe(sram_nwe1),
    .sram_nen(sram_nen1), .sram_dout(sram_dout1)
  );

  // SRAM models: asynchronous read, write while both strobes are low.
  assign sram_dout  = mem[sram_addr];
  assign sram_dout1 = mem1[sram_addr1];
  always @(posedge clk) if (!sram_nen && !sram_nwe) mem[sram_addr] <= sram_din;
  always @(posedge clk) if (!sram_nen1 && !sram_nwe1) mem1[sram_addr1] <= sram_din1;

  task automatic do_txn(input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
    logic exp_nen, exp_nwe, exp_ack, exp_busy;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0; we = 1'($urandom); addr = AB'($urandom); wdata = DB'($urandom);
      end
      exp_nen  = !(k <= W + 2);
      exp_nwe  = !(w && k >= 2 && k <= W + 1);
      exp_ack  = (k == W + 3);
      exp_busy = (k <= W + 3);
      n_checks++;
      if ({sram_nen, sram_nwe, ack, busy} !== {exp_nen, exp_nwe, exp_ack, exp_busy}) begin
        n_fail++;
        $display("FAIL txn_ctrl k=%0d we=%0b: nen/nwe/ack/busy got %b want %b", k, w,
                 {sram_nen, sram_nwe, ack, busy}, {exp_nen, exp_nwe, exp_ack, exp_busy});
      end
      n_checks++;
      if (sram_addr !== a) begin
        n_fail++;
        $display("FAIL txn_addr k=%0d: got %h want %h", k, sram_addr, a);
      end
      if (w && k <= W + 2) begin
        n_checks++;
        if (sram_din !== d) begin
          n_fail++;
          $display("FAIL txn_din k=%0d: got %h want %h", k, sram_din, d);
        end
      end
      if (k == W + 3) begin
        n_checks++;
        if (rdata !== (w ? last_rd : ref_mem[a])) begin
          n_fail++;
          $display("FAIL txn_rdata we=%0b a=%h: got %h want %h", w, a, rdata,
                   w ? last_rd : ref_mem[a]);
        end
      end
    end
    if (w) ref_mem[a] = d;
    else last_rd = ref_mem[a];
  endtask

  task automatic test_reset();
    logic exp_busy, exp_cd;
`ifdef SRAM_CLEAR_EN
    exp_busy = 1'b1; exp_cd = 1'b0;
`else
    exp_busy = 1'b0; exp_cd = 1'b1;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({sram_nen, sram_nwe, ack, busy, clr_done} !== {1'b1, 1'b1, 1'b0, exp_busy, exp_cd}) begin
      n_fail++;
      $display("FAIL reset_ctrl: nen/nwe/ack/busy/clr_done got %b want %b",
               {sram_nen, sram_nwe, ack, busy, clr_done}, {1'b1, 1'b1, 1'b0, exp_busy, exp_cd});
    end
    n_checks++;
    if ({sram_addr, sram_din, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr/din/rdata got %h/%h/%h want 0", sram_addr, sram_din, rdata);
    end
  endtask

  task automatic test_init();
`ifdef SRAM_CLEAR_EN
    int cnt;
    int k;
    logic ack_seen, not_busy;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = AB'(DEPTH - 1); reset = 1'b0;
    #1;
    cnt = 0; ack_seen = 1'b0; not_busy = 1'b0;
    while (!clr_done && cnt < 9000) begin
      if (ack) ack_seen = 1'b1;
      if (!busy) not_busy = 1'b1;
      cnt++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (cnt != DEPTH * (W + 2)) begin
      n_fail++;
      $display("FAIL clear_len: got %0d cycles want %0d", cnt, DEPTH * (W + 2));
    end
    n_checks++;
    if (ack_seen || not_busy) begin
      n_fail++;
      $display("FAIL clear_flags: ack_seen=%0b not_busy=%0b want 0/0", ack_seen, not_busy);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    k = 0;
    while (!ack && k < 20) begin
      @(negedge clk); k++;
    end
    req = 1'b0;
    n_checks++;
    if (k != W + 3) begin
      n_fail++;
      $display("FAIL clear_first_ack: got %0d cycles want %0d", k, W + 3);
    end
    n_checks++;
    if (rdata !== 8'h00 || sram_addr !== AB'(DEPTH - 1)) begin
      n_fail++;
      $display("FAIL clear_first_read: rdata/addr got %h/%h want 00/%h", rdata, sram_addr, AB'(DEPTH - 1));
    end
    last_rd = '0;
    repeat (2) @(negedge clk);
`else
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, clr_done, sram_nen, ack} !== 4'b0110) begin
      n_fail++;
      $display("FAIL init_idle: busy/clr_done/nen/ack got %b want 0110", {busy, clr_done, sram_nen, ack});
    end
`endif
  endtask

  task automatic test_directed();
    do_txn(1'b1, 11'h123, 8'hA5);
    do_txn(1'b0, 11'h123, 8'h00);
    do_txn(1'b1, 11'h000, 8'h3C);
  endtask

  task automatic test_back_to_back();
    logic exp_nen, exp_ack, exp_busy;
    logic [AB-1:0] exp_addr;
    do_txn(1'b1, 11'h010, 8'h11);
    do_txn(1'b1, 11'h020, 8'h22);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 11'h010;
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) addr = 11'h020;
      if (k == 7) req = 1'b0;
      exp_nen  = !((k >= 1 && k <= 4) || (k >= 7 && k <= 10));
      exp_ack  = (k == 5) || (k == 11);
      exp_busy = (k <= 5) || (k >= 7 && k <= 11);
      exp_addr = (k <= 6) ? 11'h010 : 11'h020;
      n_checks++;
      if ({sram_nen, ack, busy} !== {exp_nen, exp_ack, exp_busy} || sram_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL b2b k=%0d: nen/ack/busy %b addr %h want %b addr %h", k,
                 {sram_nen, ack, busy}, sram_addr, {exp_nen, exp_ack, exp_busy}, exp_addr);
      end
      if (k == 5 || k == 11) begin
        n_checks++;
        if (rdata !== ref_mem[exp_addr]) begin
          n_fail++;
          $display("FAIL b2b_rdata k=%0d: got %h want %h", k, rdata, ref_mem[exp_addr]);
        end
      end
    end
    last_rd = ref_mem[11'h020];
  endtask

  task automatic test_wait1();
    logic exp_nen, exp_nwe, exp_ack;
    @(negedge clk);
    req1 = 1'b1; we = 1'b1; addr = 11'h055; wdata = 8'h5A;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req1 = 1'b0; addr = '0; wdata = '0;
      end
      exp_nen = !(k <= 3);
      exp_nwe = !(k == 2);
      exp_ack = (k == 4);
      n_checks++;
      if ({sram_nen1, sram_nwe1, ack1} !== {exp_nen, exp_nwe, exp_ack}) begin
        n_fail++;
        $display("FAIL wait1 k=%0d: nen/nwe/ack got %b want %b", k,
                 {sram_nen1, sram_nwe1, ack1}, {exp_nen, exp_nwe, exp_ack});
      end
    end
    n_checks++;
    if (mem1[11'h055] !== 8'h5A) begin
      n_fail++;
      $display("FAIL wait1_mem: got %h want 5a", mem1[11'h055]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_txn(1'($urandom_range(0, 1)), AB'($urandom_range(0, 31)), DB'($urandom));
  endtask

  task automatic test_reset_mid();
    logic exp_busy, exp_cd, ack_seen;
`ifdef SRAM_CLEAR_EN
    exp_busy = 1'b1; exp_cd = 1'b0;
`else
    exp_busy = 1'b0; exp_cd = 1'b1;
`endif
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 11'h2AA; wdata = 8'h77;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({sram_nen, sram_nwe} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_pre: nen/nwe got %b want 00", {sram_nen, sram_nwe});
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({sram_nen, sram_nwe, ack, busy, clr_done} !== {1'b1, 1'b1, 1'b0, exp_busy, exp_cd}) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: nen/nwe/ack/busy/clr_done got %b want %b",
               {sram_nen, sram_nwe, ack, busy, clr_done}, {1'b1, 1'b1, 1'b0, exp_busy, exp_cd});
    end
    n_checks++;
    if ({sram_addr, sram_din, rdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_data: addr/din/rdata got %h/%h/%h want 0", sram_addr, sram_din, rdata);
    end
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
    end
    n_checks++;
    if (ack_seen) begin
      n_fail++;
      $display("FAIL rstmid_noack: ack pulsed after abandoned write, want none");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SRAM_CLEAR_EN
      mem[i] = 8'hFF;
      mem1[i] = 8'hFF;
      ref_mem[i] = 8'hFF;
`else
      mem[i] = 8'(i * 3 + 1);
      mem1[i] = 8'(i * 3 + 1);
      ref_mem[i] = 8'(i * 3 + 1);
`endif
    end
    test_reset();
    test_init();
    test_directed();
    test_back_to_back();
    test_wait1();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
